// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI main between N_REQ requesters, sequencing
// grant, start pulse, done handshake and a one-cycle response, with a watchdog abort.
module spi_xfer_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] tx_flat,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic [DATA_W-1:0]       spi_tx,
  input  logic [DATA_W-1:0]       spi_rx,
  input  logic                    spi_done
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_REQ - 1);
  localparam logic [WDOG_W-1:0] WdogLast = WDOG_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLaunch   = 3'd1;
  localparam logic [2:0] StWaitAck  = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  vld_q, vld_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] tx_q, tx_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  int                cand;

  // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(N_REQ)) begin
        cand = cand - int'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wdog_d   = wdog_q;
    gnt_d    = gnt_q;
    vld_d    = '0;
    err_d    = 1'b0;
    start_d  = 1'b0;
    data_d   = data_q;
    tx_d     = tx_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d = pick_idx;
          gnt_d   = pick_onehot;
          tx_d    = tx_flat[pick_idx*DATA_W +: DATA_W];
          start_d = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        wdog_d  = '0;
        state_d = StWaitAck;
      end
      StWaitAck, StWaitDone: begin
        if (wdog_q != WdogLast) begin
          wdog_d = wdog_q + 1'b1;
        end
        // A done seen in WaitDone beats a watchdog expiry in the same cycle.
        if (state_q == StWaitDone && spi_done) begin
          data_d  = spi_rx;
          vld_d   = gnt_q;
          state_d = StResp;
        end else if (wdog_q == WdogLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          vld_d   = gnt_q;
          state_d = StResp;
        end else if (state_q == StWaitAck && !spi_done) begin
          state_d = StWaitDone;
        end
      end
      StResp: begin
        gnt_d    = '0;
        rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
        state_d  = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wdog_q   <= '0;
      gnt_q    <= '0;
      vld_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wdog_q   <= wdog_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      start_q  <= start_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_data  = data_q;
  assign spi_start = start_q;
  assign spi_tx    = tx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: directed scenarios with literal expectations plus a
// cycle-level transfer model that is compared against every DUT output each cycle.
module tb_spi_xfer_arbiter;

  localparam int NR = 2;
  localparam int DW = 128;
  localparam int TO = 16;

  localparam logic [DW-1:0] TX0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] TX1 = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] tx_flat;
  logic [NR-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_data, spi_tx, spi_rx;
  logic             rsp_err, spi_start, spi_done;

  spi_xfer_arbiter #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_flat(tx_flat), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transfer model ----------------
  // age counts cycles since the start pulse; a transfer completes on the first done=1
  // after done has been seen low, or aborts after TO wait cycles.
  bit            m_busy, m_resp, m_err, m_acked;
  int            m_owner, m_ptr, m_age;
  logic [DW-1:0] m_tx, m_data;

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_resp <= 0; m_err <= 0; m_acked <= 0;
      m_owner <= 0; m_ptr <= 0; m_age <= 0; m_tx <= '0; m_data <= '0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_busy  <= 1;
        m_owner <= rr_pick(req, m_ptr);
        m_tx    <= tx_flat[rr_pick(req, m_ptr)*DW +: DW];
        m_age   <= 0;
        m_acked <= 0;
      end
    end else if (m_resp) begin
      m_busy <= 0;
      m_resp <= 0;
      m_ptr  <= (m_owner + 1) % NR;
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 1) begin
        if (m_acked && spi_done) begin
          m_resp <= 1; m_err <= 0; m_data <= spi_rx;
        end else if (m_age == TO) begin
          m_resp <= 1; m_err <= 1; m_data <= '0;
        end else if (!spi_done) begin
          m_acked <= 1;
        end
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("gnt", DW'(gnt), m_busy ? DW'(1 << m_owner) : '0);
      chk("spi_start", DW'(spi_start), DW'(m_busy && m_age == 0));
      chk("spi_tx", spi_tx, m_tx);
      chk("rsp_valid", DW'(rsp_valid), m_resp ? DW'(1 << m_owner) : '0);
      chk("rsp_err", DW'(rsp_err), DW'(m_resp && m_err));
      if (m_resp) chk("rsp_data", rsp_data, m_data);
    end
  end

  // ---------------- SPI main model (loopback) ----------------
  int            ack_dly = 1;
  int            lat = 3;
  bit            hang = 0;
  logic [DW-1:0] tx_seen, tx_at_done;

  initial begin
    spi_done = 1'b0;
    spi_rx = '0;
    tx_at_done = '0;
    tx_seen = '0;
    forever begin
      @(posedge clk); #1;
      if (spi_start && !hang) begin
        tx_seen = spi_tx;
        repeat (ack_dly) @(posedge clk);
        #1 spi_done = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        tx_at_done = spi_tx;
        spi_rx = tx_seen;
        spi_done = 1'b1;
      end
    end
  end

  // ---------------- requester side ----------------
  int            start_cyc, rsp_cyc, n_starts;
  logic [NR-1:0] last_vld;
  logic [DW-1:0] last_data;
  logic          last_err;
  bit            drop_on_rsp = 1;
  int            order[$];

  task automatic run_rsps(input int n, input int maxcyc);
    int got = 0;
    int k = 0;
    n_starts = 0;
    while (got < n && k < maxcyc) begin
      @(posedge clk); #1;
      k++;
      if (spi_start) begin
        n_starts++;
        start_cyc = cyc;
      end
      if (rsp_valid != '0) begin
        last_vld = rsp_valid; last_data = rsp_data; last_err = rsp_err; rsp_cyc = cyc;
        order.push_back(rsp_valid[1] ? 1 : 0);
        got++;
        if (drop_on_rsp) req = req & ~rsp_valid;
        if (got == n) req = '0;
      end
    end
    if (got < n) chk("rsp_timeout", DW'(got), DW'(n));
  endtask

  task automatic wait_start(input int maxcyc);
    int k = 0;
    while (!spi_start && k < maxcyc) begin
      @(posedge clk); #1;
      k++;
    end
    if (!spi_start) chk("start_timeout", DW'(spi_start), DW'(1));
    start_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int stray;
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1;
    req = '0;
    tx_flat = {TX1, TX0};
    @(posedge clk); #1;
    chk("rst_gnt", DW'(gnt), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_rsp_err", DW'(rsp_err), '0);
    chk("rst_spi_start", DW'(spi_start), '0);
    chk("rst_spi_tx", spi_tx, '0);
    chk("rst_rsp_data", rsp_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single transfer from requester 0
    req = 2'b01;
    run_rsps(1, 50);
    chk("t1_starts", DW'(n_starts), DW'(1));
    chk("t1_tx_seen", tx_seen, TX0);
    chk("t1_vld", DW'(last_vld), DW'(2'b01));
    chk("t1_data", last_data, TX0);
    chk("t1_err", DW'(last_err), '0);
    chk("t1_latency", DW'(rsp_cyc - start_cyc), DW'(5));

    // 6: done stays high for 4 cycles after start; stale done must not complete it
    ack_dly = 4;
    req = 2'b10;
    run_rsps(1, 50);
    chk("t6_vld", DW'(last_vld), DW'(2'b10));
    chk("t6_data", last_data, TX1);
    chk("t6_latency", DW'(rsp_cyc - start_cyc), DW'(8));
    ack_dly = 1;

    // 2: both requesting continuously for 4 transfers
    order.delete();
    drop_on_rsp = 0;
    req = 2'b11;
    run_rsps(4, 100);
    drop_on_rsp = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_order%0d", i), DW'(order.size() > i ? order[i] : -1),
          DW'(exp_order[i]));
    end

    // 5: tx_flat slice 0 changes after the grant
    req = 2'b01;
    wait_start(20);
    tx_flat[DW-1:0] = '1;
    run_rsps(1, 50);
    chk("t5_data", last_data, TX0);
    chk("t5_tx_at_done", tx_at_done, TX0);
    tx_flat[DW-1:0] = TX0;

    // 3: SPI main never drops done -> watchdog abort, then a normal transfer
    hang = 1;
    req = 2'b10;
    run_rsps(1, 100);
    chk("t3_vld", DW'(last_vld), DW'(2'b10));
    chk("t3_err", DW'(last_err), DW'(1));
    chk("t3_data", last_data, '0);
    chk("t3_latency", DW'(rsp_cyc - start_cyc), DW'(TO + 1));
    hang = 0;
    req = 2'b01;
    run_rsps(1, 50);
    chk("t3_next_vld", DW'(last_vld), DW'(2'b01));
    chk("t3_next_err", DW'(last_err), '0);
    chk("t3_next_data", last_data, TX0);

    // done arrives in the very cycle the watchdog expires: completion wins
    lat = TO - 1;
    req = 2'b01;
    run_rsps(1, 100);
    chk("tw_err", DW'(last_err), '0);
    chk("tw_data", last_data, TX0);
    chk("tw_latency", DW'(rsp_cyc - start_cyc), DW'(TO + 1));

    // 4: reset during WaitDone while requester 1 holds the grant
    lat = 10;
    req = 2'b10;
    wait_start(20);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_gnt_before", DW'(gnt), DW'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("t4_gnt_rst", DW'(gnt), '0);
    chk("t4_start_rst", DW'(spi_start), '0);
    req = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (rsp_valid != '0) stray++;
    end
    chk("t4_no_rsp", DW'(stray), '0);
    lat = 3;
    req = 2'b11;
    run_rsps(1, 50);
    chk("t4_first_gnt", DW'(last_vld), DW'(2'b01));
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
